// File: rtl/stack_mem_ram.sv
// rtl/stack_mem_ram.sv - writable program/data store with clear, boot-load and registered read path
module stack_mem_ram #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(15)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_load,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_ready,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range;
    logic              at_last;
    logic              we;
    logic [IDX_W-1:0]  wa;
    logic [DATA_W-1:0] wd;

    assign in_range = ({1'b0, mem_addr} < DEPTH_L);
    assign at_last  = (ptr_q == LAST_PTR);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        addr_err_d = addr_err_q;
        we         = 1'b0;
        wa         = ptr_q[IDX_W-1:0];
        wd         = FILL;
        case (state_q)
            S_CLEAR: begin
                we = 1'b1;
                if (at_last) begin
                    ptr_d   = '0;
                    state_d = boot_load ? S_LOAD : S_RUN;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    we = 1'b1;
                    wd = ld_data;
                    if (ld_last || at_last) begin
                        ptr_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (wr_en && in_range) begin
                    we = 1'b1;
                    wa = mem_addr[IDX_W-1:0];
                    wd = data_in;
                end
                // Read samples the array before this edge's write lands: read-first.
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    data_out_d = in_range ? mem_q[mem_addr[IDX_W-1:0]] : FILL;
                end
                if ((rd_en || wr_en) && !in_range) begin
                    addr_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
        if (rst) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            ptr_q      <= '0;
            data_out_q <= FILL;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Contents are not reset; the CLEAR sweep overwrites every word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign ld_ready  = (state_q == S_LOAD);
    assign mem_ready = (state_q == S_RUN);
    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_stack_mem_ram.sv
// tb/tb_stack_mem_ram.sv - scoreboard bench for stack_mem_ram at DEPTH=32
module tb_stack_mem_ram;

    localparam int         DEPTH = 32;
    localparam logic [7:0] FILLV = 8'd15;

    logic       clk = 1'b0;
    logic       rst, boot_load, ld_valid, ld_last, rd_en, wr_en;
    logic [7:0] ld_data, mem_addr, data_in, data_out;
    logic       ld_ready, mem_ready, rd_valid, addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] sb [$];
    logic [7:0] rq [$];

    always #5 clk = ~clk;

    stack_mem_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .FILL(FILLV)) dut (
        .clk(clk), .rst(rst), .boot_load(boot_load),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .mem_ready(mem_ready), .rd_en(rd_en), .wr_en(wr_en), .mem_addr(mem_addr),
        .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .addr_err(addr_err)
    );

    function automatic logic [7:0] model_read(input logic [7:0] a);
        return (a < DEPTH) ? model_mem[a[4:0]] : FILLV;
    endfunction

    task automatic reset_clear(input logic bl, input string tag);
        rst = 1'b1; boot_load = bl; rd_en = 1'b0; wr_en = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00; mem_addr = 8'h00; data_in = 8'h00;
        @(posedge clk); #1;
        n_checks++;
        if ({ld_ready, mem_ready, rd_valid, addr_err} !== 4'b0000 || data_out !== FILLV) begin
            n_fail++;
            $display("FAIL %s reset_state: ld_ready=%b mem_ready=%b rd_valid=%b addr_err=%b data_out=%0d, want 0 0 0 0 15",
                     tag, ld_ready, mem_ready, rd_valid, addr_err, data_out);
        end
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i <= 20) begin
                rd_en = 1'b1; wr_en = 1'b1; mem_addr = 8'd1; data_in = 8'h77; ld_valid = 1'b1; ld_data = 8'h99;
            end else begin
                rd_en = 1'b0; wr_en = 1'b0; ld_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if (i < DEPTH) begin
                if ({ld_ready, mem_ready, rd_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s clear_cycle%0d: ld_ready=%b mem_ready=%b rd_valid=%b, want 0 0 0",
                             tag, i, ld_ready, mem_ready, rd_valid);
                end
            end else if ({ld_ready, mem_ready} !== (bl ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s clear_exit: ld_ready=%b mem_ready=%b, want %b %b",
                         tag, ld_ready, mem_ready, bl, ~bl);
            end
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILLV;
    endtask

    task automatic run_reads(input string tag);
        logic [7:0] a, exp, last;
        last = 8'h00;
        foreach (rq[i]) begin
            a = rq[i];
            rd_en = 1'b1; mem_addr = a;
            sb.push_back(model_read(a));
            @(posedge clk); #1;
            n_checks++;
            if (rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s rd_valid[%0d]: got %b, want 1", tag, a, rd_valid);
            end else begin
                exp  = sb.pop_front();
                last = exp;
                if (data_out !== exp) begin
                    n_fail++;
                    $display("FAIL %s data[%0d]: got %0d, want %0d", tag, a, data_out, exp);
                end
            end
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid !== 1'b0 || data_out !== last || sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s idle: rd_valid=%b data_out=%0d pending=%0d, want 0 %0d 0",
                     tag, rd_valid, data_out, sb.size(), last);
        end
        sb.delete();
        rq.delete();
    endtask

    task automatic test_no_boot();
        reset_clear(1'b0, "noboot");
        for (int i = 0; i < DEPTH; i++) rq.push_back(8'(i));
        run_reads("noboot");
    endtask

    task automatic test_boot_load();
        logic [7:0] bytes [8];
        logic       vld [8];
        int         k;
        bytes = '{8'd8, 8'd10, 8'd8, 8'd0, 8'd0, 8'd20, 8'd0, 8'd14};
        vld   = '{1, 1, 1, 0, 0, 1, 1, 1};
        reset_clear(1'b1, "boot");
        k = 0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = vld[i]; ld_data = bytes[i]; ld_last = (i == 7);
            if (vld[i]) begin model_mem[k] = bytes[i]; k++; end
            @(posedge clk); #1;
            n_checks++;
            if (i < 7 && {ld_ready, mem_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL boot load_beat%0d: ld_ready=%b mem_ready=%b, want 1 0", i, ld_ready, mem_ready);
            end else if (i == 7 && {ld_ready, mem_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL boot load_exit: ld_ready=%b mem_ready=%b, want 0 1", ld_ready, mem_ready);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int i = 0; i <= 6; i++) rq.push_back(8'(i));
        run_reads("boot");
    endtask

    task automatic test_load_overflow();
        reset_clear(1'b1, "ovf");
        for (int i = 1; i <= 40; i++) begin
            ld_valid = 1'b1; ld_data = 8'((i - 1) * 7 + 3); ld_last = 1'b0;
            if (i <= DEPTH) model_mem[i-1] = ld_data;
            @(posedge clk); #1;
            n_checks++;
            if (i < DEPTH && {ld_ready, mem_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL ovf beat%0d: ld_ready=%b mem_ready=%b, want 1 0", i, ld_ready, mem_ready);
            end else if (i >= DEPTH && {ld_ready, mem_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL ovf after%0d: ld_ready=%b mem_ready=%b, want 0 1", i, ld_ready, mem_ready);
            end
        end
        ld_valid = 1'b0;
        rq = '{8'd31, 8'd0, 8'd1, 8'd30};
        run_reads("ovf");
    endtask

    task automatic test_read_first();
        logic [7:0] exp;
        wr_en = 1'b1; mem_addr = 8'd18; data_in = 8'h0C;
        model_mem[18] = 8'h0C;
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h55;
        sb.push_back(model_mem[18]);
        model_mem[18] = 8'h55;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rdfirst valid: got %b, want 1", rd_valid);
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (data_out !== exp) begin
                n_fail++;
                $display("FAIL rdfirst old_word: got %0d, want %0d", data_out, exp);
            end
        end
        rq = '{8'd18, 8'd3, 8'd4, 8'd5};
        run_reads("b2b");
    endtask

    task automatic test_out_of_range();
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor err_before: got %b, want 0", addr_err);
        end
        wr_en = 1'b1; mem_addr = 8'd40; data_in = 8'hAA;
        @(posedge clk); #1;
        wr_en = 1'b0;
        n_checks++;
        if (addr_err !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL oor write_err: addr_err=%b rd_valid=%b, want 1 0", addr_err, rd_valid);
        end
        rq = '{8'd40, 8'd8, 8'd255};
        run_reads("oor");
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor sticky: got %b, want 1", addr_err);
        end
    endtask

    task automatic test_reset_mid();
        reset_clear(1'b1, "mid1");
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 8'(8'h21 + i); ld_last = 1'b0;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        reset_clear(1'b0, "mid2");
        rq = '{8'd0, 8'd1, 8'd2, 8'd3};
        run_reads("mid");
        rd_en = 1'b1; mem_addr = 8'd0; rst = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0; rst = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL squash: rd_valid=%b mem_ready=%b, want 0 0", rd_valid, mem_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_after: rd_valid=%b, want 0", rd_valid);
        end
    endtask

    initial begin
        test_no_boot();
        test_boot_load();
        test_load_overflow();
        test_read_first();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
